// File: rtl/soc_mem_loader_pkg.sv
// Shared definitions for the soc_mem_loader boot loader.
//  - state_e        : loader FSM states
//  - HDR_*_BYTES    : header field sizes in bytes (little-endian on the wire)
//  - CHAN_W         : width of the stored channel index (up to 8 memories)
package soc_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_LEN   = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DROP  = 3'd5
    } state_e;

    localparam int HDR_ADDR_BYTES = 4;
    localparam int HDR_LEN_BYTES  = 4;
    localparam int CHAN_W         = 3;
    // Header byte counter width; both header fields are 4 bytes long.
    localparam int HDR_CNT_W      = 2;

endpackage

// File: rtl/soc_mem_loader_pack.sv
// Byte-lane word buffer for soc_mem_loader.
// Collects payload bytes into one memory word, one byte lane at a time, and
// tracks which lanes hold data.
// Ports:
//  clk, reset  clock / synchronous active-high reset (clears buffer and strobes)
//  byte_we_i   store byte_i into lane lane_i this cycle
//  lane_i      byte lane (byte-address offset within the word)
//  byte_i      payload byte
//  last_i      the byte being stored is the last payload byte of the frame
//  clr_i       drop buffer contents and strobes (word has been written)
//  data_o      buffered word; lanes without a strobe read as 0
//  strb_o      per-lane byte enables
//  full_o      this store fills the top lane, so the word is complete
//  flush_o     this store is the final byte of the frame, so the word must go out
// BPW is assumed to be a power of two so that lanes map directly onto address bits.
module soc_mem_loader_pack #(
    parameter int BPW    = 4,
    parameter int LANE_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_we_i,
    input  logic [LANE_W-1:0] lane_i,
    input  logic [7:0]        byte_i,
    input  logic              last_i,
    input  logic              clr_i,
    output logic [BPW*8-1:0]  data_o,
    output logic [BPW-1:0]    strb_o,
    output logic              full_o,
    output logic              flush_o
);

    logic [BPW-1:0][7:0] data_q, data_d;
    logic [BPW-1:0]      strb_q, strb_d;

    always_comb begin
        data_d = data_q;
        strb_d = strb_q;
        if (clr_i) begin
            data_d = '0;
            strb_d = '0;
        end else if (byte_we_i) begin
            data_d[lane_i] = byte_i;
            strb_d[lane_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            strb_q <= '0;
        end else begin
            data_q <= data_d;
            strb_q <= strb_d;
        end
    end

    assign data_o  = data_q;
    assign strb_o  = strb_q;
    assign full_o  = byte_we_i & (lane_i == LANE_W'(BPW - 1));
    assign flush_o = byte_we_i & last_i;

endmodule

// File: rtl/soc_mem_loader.sv
// Hardware boot loader: parses a framed byte stream and writes its payload into
// one of NUM_CHAN memories, packed little-endian into DATA_WIDTH words.
// Frame: CHAN(1) ADDR(4, LE) LEN(4, LE byte count) then LEN payload bytes.
// Ports:
//  clk, reset    clock / synchronous active-high reset
//  in_valid/in_data/in_ready   byte stream, accepted on in_valid & in_ready
//  wr_valid/wr_ready           memory write handshake
//  wr_chan       one-hot target memory
//  wr_addr       word address
//  wr_data       write data, lane k = byte at byte offset k (0 where strobe is 0)
//  wr_strb       byte enables
//  load_active   high while a frame is in progress
//  done          1-cycle pulse at frame end
//  err_chan      1-cycle pulse when the frame names a nonexistent channel
module soc_mem_loader
    import soc_mem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_CHAN   = 2
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         in_valid,
    input  logic [7:0]                                   in_data,
    output logic                                         in_ready,
    output logic                                         wr_valid,
    input  logic                                         wr_ready,
    output logic [NUM_CHAN-1:0]                          wr_chan,
    output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]                        wr_data,
    output logic [DATA_WIDTH/8-1:0]                      wr_strb,
    output logic                                         load_active,
    output logic                                         done,
    output logic                                         err_chan
);

    localparam int BPW    = DATA_WIDTH / 8;
    localparam int LB     = $clog2(BPW);
    localparam int LANE_W = (LB > 0) ? LB : 1;
    localparam int WAW    = ADDR_WIDTH - LB;
    localparam logic [7:0] NUM_CHAN_B = 8'(NUM_CHAN);
    localparam logic [HDR_CNT_W-1:0] ADDR_LAST = HDR_CNT_W'(HDR_ADDR_BYTES - 1);
    localparam logic [HDR_CNT_W-1:0] LEN_LAST  = HDR_CNT_W'(HDR_LEN_BYTES - 1);

    state_e                state_q, state_d;
    logic [HDR_CNT_W-1:0]  hdr_cnt_q, hdr_cnt_d;
    logic [31:0]           hdr_q, hdr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           rem_q, rem_d;
    logic [CHAN_W-1:0]     chan_q, chan_d;
    logic                  chan_bad_q, chan_bad_d;
    logic [WAW-1:0]        word_addr_q, word_addr_d;
    logic                  load_active_q, load_active_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  in_write;
    logic [31:0]           hdr_next;
    logic [LANE_W-1:0]     lane;
    logic                  pk_we, pk_clr, pk_full, pk_flush;
    logic [DATA_WIDTH-1:0] pk_data;
    logic [BPW-1:0]        pk_strb;

    // The low address bits select the byte lane; a one-lane word has only lane 0.
    generate
        if (LB > 0) begin : g_lane
            assign lane = addr_q[LB-1:0];
        end else begin : g_lane0
            assign lane = '0;
        end
    endgenerate

    soc_mem_loader_pack #(
        .BPW    (BPW),
        .LANE_W (LANE_W)
    ) u_pack (
        .clk       (clk),
        .reset     (reset),
        .byte_we_i (pk_we),
        .lane_i    (lane),
        .byte_i    (in_data),
        .last_i    (rem_q == 32'd1),
        .clr_i     (pk_clr),
        .data_o    (pk_data),
        .strb_o    (pk_strb),
        .full_o    (pk_full),
        .flush_o   (pk_flush)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            hdr_cnt_q     <= '0;
            hdr_q         <= '0;
            addr_q        <= '0;
            rem_q         <= '0;
            chan_q        <= '0;
            chan_bad_q    <= 1'b0;
            word_addr_q   <= '0;
            load_active_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            hdr_cnt_q     <= hdr_cnt_d;
            hdr_q         <= hdr_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            chan_q        <= chan_d;
            chan_bad_q    <= chan_bad_d;
            word_addr_q   <= word_addr_d;
            load_active_q <= load_active_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hdr_cnt_d     = hdr_cnt_q;
        hdr_d         = hdr_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        chan_d        = chan_q;
        chan_bad_d    = chan_bad_q;
        word_addr_d   = word_addr_q;
        load_active_d = load_active_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        pk_we         = 1'b0;
        pk_clr        = 1'b0;

        in_write = (state_q == ST_WRITE);
        in_ready = ~in_write;
        accept   = in_valid & ~in_write;
        // Header fields arrive LSB first: shift each byte in from the top.
        hdr_next = {in_data, hdr_q[31:8]};

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    chan_d        = in_data[CHAN_W-1:0];
                    chan_bad_d    = (in_data >= NUM_CHAN_B);
                    load_active_d = 1'b1;
                    hdr_cnt_d     = '0;
                    state_d       = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (accept) begin
                    hdr_d     = hdr_next;
                    hdr_cnt_d = hdr_cnt_q + 1'b1;
                    if (hdr_cnt_q == ADDR_LAST) begin
                        addr_d    = hdr_next[ADDR_WIDTH-1:0];
                        hdr_cnt_d = '0;
                        state_d   = ST_LEN;
                    end
                end
            end
            ST_LEN: begin
                if (accept) begin
                    hdr_d     = hdr_next;
                    hdr_cnt_d = hdr_cnt_q + 1'b1;
                    if (hdr_cnt_q == LEN_LAST) begin
                        rem_d     = hdr_next;
                        hdr_cnt_d = '0;
                        if (hdr_next == 32'd0) begin
                            done_d        = 1'b1;
                            load_active_d = 1'b0;
                            state_d       = ST_IDLE;
                        end else if (chan_bad_q) begin
                            err_d   = 1'b1;
                            state_d = ST_DROP;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    pk_we       = 1'b1;
                    // Word address is captured per byte so a word straddling
                    // the wrap point is addressed by its own bytes.
                    word_addr_d = addr_q[ADDR_WIDTH-1:LB];
                    addr_d      = addr_q + 1'b1;
                    rem_d       = rem_q - 32'd1;
                    if (pk_full | pk_flush) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (wr_ready) begin
                    pk_clr = 1'b1;
                    if (rem_q == 32'd0) begin
                        done_d        = 1'b1;
                        load_active_d = 1'b0;
                        state_d       = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DROP: begin
                if (accept) begin
                    rem_d = rem_q - 32'd1;
                    if (rem_q == 32'd1) begin
                        done_d        = 1'b1;
                        load_active_d = 1'b0;
                        state_d       = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Write-side outputs are forced to 0 outside WRITE so idle buses are quiet.
        wr_valid = in_write;
        wr_chan  = in_write ? (NUM_CHAN'(1) << chan_q) : '0;
        wr_addr  = in_write ? word_addr_q : '0;
        wr_data  = in_write ? pk_data : '0;
        wr_strb  = in_write ? pk_strb : '0;
    end

    assign load_active = load_active_q;
    assign done        = done_q;
    assign err_chan    = err_q;

endmodule

// File: tb/tb_soc_mem_loader.sv
module tb_soc_mem_loader;

    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int NC  = 2;
    localparam int BPW = 4;
    localparam int WAW = AW - 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic [7:0]     in_data = 8'h00;
    logic           wr_ready = 1'b1;
    logic           in_ready, wr_valid, load_active, done, err_chan;
    logic [NC-1:0]  wr_chan;
    logic [WAW-1:0] wr_addr;
    logic [DW-1:0]  wr_data;
    logic [BPW-1:0] wr_strb;

    always #5 clk = ~clk;

    soc_mem_loader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_CHAN   (NC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_chan     (wr_chan),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_strb     (wr_strb),
        .load_active (load_active),
        .done        (done),
        .err_chan    (err_chan)
    );

    typedef struct packed {
        logic [NC-1:0]  chan;
        logic [WAW-1:0] addr;
        logic [DW-1:0]  data;
        logic [BPW-1:0] strb;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        act_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         done_seen = 0;
    int         err_seen = 0;
    int         done_exp = 0;
    int         err_exp = 0;
    logic [7:0] pay [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: walk the payload byte by byte over a byte-addressed space and
    // emit a write whenever the next byte lands in a different word.
    task automatic model_frame(input logic [7:0] ch, input logic [31:0] ad, input int ln);
        int             a;
        int             cw;
        logic [DW-1:0]  d;
        logic [BPW-1:0] s;
        wr_t            w;
        if (ch >= NC || ln == 0) return;
        a  = int'(ad % (1 << AW));
        cw = -1;
        d  = '0;
        s  = '0;
        for (int i = 0; i < ln; i++) begin
            if (s != 0 && (a / BPW) != cw) begin
                w.chan = NC'(1) << ch; w.addr = WAW'(cw); w.data = d; w.strb = s;
                exp_q.push_back(w);
                d = '0;
                s = '0;
            end
            cw = a / BPW;
            d[(a % BPW) * 8 +: 8] = pay[i];
            s[a % BPW] = 1'b1;
            a = (a + 1) % (1 << AW);
        end
        if (s != 0) begin
            w.chan = NC'(1) << ch; w.addr = WAW'(cw); w.data = d; w.strb = s;
            exp_q.push_back(w);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        #1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: byte %h never accepted", b);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] ch, input logic [31:0] ad, input logic [31:0] ln);
        model_frame(ch, ad, int'(ln));
        done_exp++;
        if (ch >= NC && ln != 0) err_exp++;
        send_byte(ch);
        for (int i = 0; i < 4; i++) send_byte(ad[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(ln[8*i +: 8]);
        for (int i = 0; i < int'(ln); i++) send_byte(pay[i]);
    endtask

    task automatic finish_frame(input string name);
        int t;
        t = 0;
        while (done_seen != done_exp && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk({name, "_done_count"}, 64'(done_seen), 64'(done_exp));
        chk({name, "_err_count"}, 64'(err_seen), 64'(err_exp));
        chk({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_load_active_low"}, 64'(load_active), 64'd0);
    endtask

    task automatic chk_wr(input string name, input int idx, input logic [NC-1:0] c,
                          input logic [WAW-1:0] a, input logic [DW-1:0] d, input logic [BPW-1:0] s);
        wr_t w;
        if (idx >= act_q.size()) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: write %0d missing, only %0d seen", name, idx, act_q.size());
        end else begin
            w = act_q[idx];
            chk({name, "_chan"}, 64'(w.chan), 64'(c));
            chk({name, "_addr"}, 64'(w.addr), 64'(a));
            chk({name, "_data"}, 64'(w.data), 64'(d));
            chk({name, "_strb"}, 64'(w.strb), 64'(s));
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({name, "_wr_bus"}, 64'({wr_valid, wr_chan, wr_addr, wr_strb}), 64'd0);
        chk({name, "_wr_data"}, 64'(wr_data), 64'd0);
        chk({name, "_flags"}, 64'({load_active, done, err_chan}), 64'd0);
    endtask

    // Per-cycle compare against the model's write queue and pulse counters.
    always begin : cmp
        wr_t           e;
        wr_t           a;
        logic [DW-1:0] m;
        @(negedge clk);
        #1;
        if (!reset) begin
            if (done) begin
                done_seen++;
                chk("done_with_load_active_low", 64'(load_active), 64'd0);
            end
            if (err_chan) err_seen++;
            if (wr_valid) begin
                for (int k = 0; k < BPW; k++) m[k*8 +: 8] = {8{wr_strb[k]}};
                chk("unstrobed_lanes_zero", 64'(wr_data & ~m), 64'd0);
                chk("in_ready_low_in_write", 64'(in_ready), 64'd0);
                if (wr_ready) begin
                    a.chan = wr_chan; a.addr = wr_addr; a.data = wr_data; a.strb = wr_strb;
                    act_q.push_back(a);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_write: addr %h data %h strb %h", wr_addr, wr_data, wr_strb);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write_vs_model", 64'(a), 64'(e));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b0;

        // 1: two aligned full words into imem
        pay[0] = 8'h13; pay[1] = 8'h05; pay[2] = 8'h00; pay[3] = 8'h00;
        pay[4] = 8'h93; pay[5] = 8'h00; pay[6] = 8'h10; pay[7] = 8'h00;
        act_q.delete();
        run_frame(8'd0, 32'h0, 32'd8);
        finish_frame("t1");
        chk("t1_nwrites", 64'(act_q.size()), 64'd2);
        chk_wr("t1_w0", 0, 2'b01, 14'h0, 32'h00000513, 4'hF);
        chk_wr("t1_w1", 1, 2'b01, 14'h1, 32'h00100093, 4'hF);

        // 2: unaligned start, short end into dmem
        pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC; pay[3] = 8'hDD; pay[4] = 8'hEE;
        act_q.delete();
        run_frame(8'd1, 32'h6, 32'd5);
        finish_frame("t2");
        chk("t2_nwrites", 64'(act_q.size()), 64'd2);
        chk_wr("t2_w0", 0, 2'b10, 14'h1, 32'hBBAA0000, 4'hC);
        chk_wr("t2_w1", 1, 2'b10, 14'h2, 32'h00EEDDCC, 4'h7);

        // 3: memory back-pressure while a word is pending
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44; pay[4] = 8'h55; pay[5] = 8'h66;
        act_q.delete();
        wr_ready = 1'b0;
        fork
            run_frame(8'd0, 32'h20, 32'd6);
            begin : stall
                int   t;
                bit   stable;
                wr_t  snap;
                t = 0;
                stable = 1'b1;
                do begin
                    @(negedge clk);
                    #1;
                    t++;
                end while (!wr_valid && t < 200);
                chk("t3_stall_wr_valid", 64'(wr_valid), 64'd1);
                snap.chan = wr_chan; snap.addr = wr_addr; snap.data = wr_data; snap.strb = wr_strb;
                repeat (10) begin
                    @(negedge clk);
                    #1;
                    if (!wr_valid || in_ready || {wr_chan, wr_addr, wr_data, wr_strb} != snap) stable = 1'b0;
                end
                chk("t3_stall_stable", 64'(stable), 64'd1);
                @(negedge clk);
                wr_ready = 1'b1;
            end
        join
        finish_frame("t3");
        chk("t3_nwrites", 64'(act_q.size()), 64'd2);
        chk_wr("t3_w0", 0, 2'b01, 14'h8, 32'h44332211, 4'hF);
        chk_wr("t3_w1", 1, 2'b01, 14'h9, 32'h00006655, 4'h3);

        // 4: nonexistent channel, payload dropped
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
        act_q.delete();
        run_frame(8'd5, 32'h40, 32'd3);
        finish_frame("t4");
        chk("t4_nwrites", 64'(act_q.size()), 64'd0);
        chk("t4_err_total", 64'(err_seen), 64'd1);

        // 5: address wrap with ignored upper address bits
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
        act_q.delete();
        run_frame(8'd1, 32'h1234FFFE, 32'd4);
        finish_frame("t5");
        chk("t5_nwrites", 64'(act_q.size()), 64'd2);
        chk_wr("t5_w0", 0, 2'b10, 14'h3FFF, 32'h02010000, 4'hC);
        chk_wr("t5_w1", 1, 2'b10, 14'h0000, 32'h00000403, 4'h3);

        // 6: reset mid-payload, then a frame into the other half of that word
        act_q.delete();
        send_byte(8'd0);
        send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h77); send_byte(8'h88);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk_reset_outputs("t6_midreset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_no_write", 64'(act_q.size()), 64'd0);
        chk("t6_no_done", 64'(done_seen), 64'(done_exp));
        pay[0] = 8'hA5; pay[1] = 8'h5A;
        run_frame(8'd0, 32'h12, 32'd2);
        finish_frame("t6");
        chk("t6_nwrites", 64'(act_q.size()), 64'd1);
        chk_wr("t6_w0", 0, 2'b01, 14'h4, 32'h5AA50000, 4'hC);

        // 7: zero-length frame
        act_q.delete();
        run_frame(8'd1, 32'h100, 32'd0);
        finish_frame("t7");
        chk("t7_nwrites", 64'(act_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
